// File: rtl/present_pkg.sv
// Shared constants, FSM state type and the PRESENT bit permutation for the
// present_enc datapath.
package present_pkg;

   localparam int STATE_W = 64;
   localparam int KEY_W   = 80;
   localparam int ROUNDS  = 31;

   // Nibble n of this constant is S(n); S(0)=C sits in the lowest nibble.
   localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2
   } fsm_e;

   function automatic logic [STATE_W-1:0] p_layer(input logic [STATE_W-1:0] s);
      logic [STATE_W-1:0] p;
      logic [5:0]         dst;
      p = '0;
      for (int i = 0; i < STATE_W - 1; i++) begin
         dst    = 6'((16 * i) % (STATE_W - 1));
         p[dst] = s[i];
      end
      p[STATE_W-1] = s[STATE_W-1];
      return p;
   endfunction

endpackage

// File: rtl/present_if.sv
// Request/result bus of present_enc plus the key-schedule side channel.
// The abort_i signal exists only when PRESENT_ABORT_EN is defined.
interface present_if;
   import present_pkg::*;

   logic               start_i;
   logic [STATE_W-1:0] pt_i;
   logic [KEY_W-1:0]   key_i;
   logic [KEY_W-1:0]   krnd_i;
`ifdef PRESENT_ABORT_EN
   logic               abort_i;
`endif
   logic               key_start_o;
   logic               key_act_o;
   logic [4:0]         rc_o;
   logic [STATE_W-1:0] ct_o;
   logic               done_o;
   logic               busy_o;

   modport slave (
`ifdef PRESENT_ABORT_EN
      input  abort_i,
`endif
      input  start_i, pt_i, key_i, krnd_i,
      output key_start_o, key_act_o, rc_o, ct_o, done_o, busy_o
   );

   modport master (
`ifdef PRESENT_ABORT_EN
      output abort_i,
`endif
      output start_i, pt_i, key_i, krnd_i,
      input  key_start_o, key_act_o, rc_o, ct_o, done_o, busy_o
   );

endinterface

// File: rtl/present_sbox.sv
// One 4-bit PRESENT S-box, purely combinational.
module present_sbox
   import present_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);

   assign nib_o = SBOX[{nib_i, 2'b00} +: 4];

endmodule

// File: rtl/present_enc.sv
// PRESENT-80 encryption core: one round per clock, round keys supplied by an
// external key-schedule stage. Optional abort input under PRESENT_ABORT_EN.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; first round computed from pt/key on start
//   ST_ROUND | rounds rc=1..30 using krnd from the key-schedule stage
//   ST_FINAL | rc=31, final key whitening into ct, done pulse
module present_enc
   import present_pkg::*;
(
   input logic      CK,
   input logic      RN,
   present_if.slave bus
);

   localparam logic [4:0] RC_LAST = 5'(ROUNDS - 1);

   fsm_e               fsm_q;
   logic [STATE_W-1:0] data_q;
   logic [STATE_W-1:0] ct_q;
   logic [4:0]         rc_q;
   logic               done_q;
   logic [STATE_W-1:0] round_in;
   logic [STATE_W-1:0] sb_out;
   logic [STATE_W-1:0] round_d;
   logic               unused_low_key;

   // The first round keys straight off the input bus; later rounds use krnd.
   assign round_in = (fsm_q == ST_IDLE)
                   ? (bus.pt_i ^ bus.key_i[KEY_W-1:KEY_W-STATE_W])
                   : (data_q   ^ bus.krnd_i[KEY_W-1:KEY_W-STATE_W]);

   for (genvar g = 0; g < STATE_W / 4; g++) begin : g_sbox
      present_sbox u_sbox (
         .nib_i (round_in[4*g +: 4]),
         .nib_o (sb_out[4*g +: 4])
      );
   end

   assign round_d = p_layer(sb_out);

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         fsm_q  <= ST_IDLE;
         data_q <= '0;
         ct_q   <= '0;
         rc_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm_q)
            ST_IDLE: begin
               if (bus.start_i) begin
                  data_q <= round_d;
                  rc_q   <= 5'd1;
                  fsm_q  <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               data_q <= round_d;
               rc_q   <= rc_q + 5'd1;
               if (rc_q == RC_LAST) fsm_q <= ST_FINAL;
            end
            ST_FINAL: begin
               ct_q   <= data_q ^ bus.krnd_i[KEY_W-1:KEY_W-STATE_W];
               done_q <= 1'b1;
               rc_q   <= '0;
               fsm_q  <= ST_IDLE;
            end
            default: begin
               rc_q  <= '0;
               fsm_q <= ST_IDLE;
            end
         endcase
`ifdef PRESENT_ABORT_EN
         // Abort wins over the FINAL write so an aborted block never lands in ct.
         if (bus.abort_i && (fsm_q != ST_IDLE)) begin
            fsm_q  <= ST_IDLE;
            rc_q   <= '0;
            done_q <= 1'b0;
            ct_q   <= ct_q;
         end
`endif
      end
   end

   assign bus.key_start_o = bus.start_i && (fsm_q == ST_IDLE);
   assign bus.key_act_o   = (fsm_q == ST_ROUND);
   assign bus.busy_o      = (fsm_q != ST_IDLE);
   assign bus.rc_o        = rc_q;
   assign bus.ct_o        = ct_q;
   assign bus.done_o      = done_q;

   assign unused_low_key = ^{bus.key_i[KEY_W-STATE_W-1:0], bus.krnd_i[KEY_W-STATE_W-1:0]};

endmodule

// File: tb/tb_present_enc.sv
// Self-checking bench for present_enc: hosts the key-schedule stage, checks
// known-answer vectors, restart/reset corner cases and random blocks.
module tb_present_enc;

   logic CK = 1'b0;
   logic RN = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   logic [79:0] ks_q;

   localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   present_if bus ();

   present_enc dut (
      .CK  (CK),
      .RN  (RN),
      .bus (bus)
   );

   always #5 CK = ~CK;
   always @(posedge CK) cyc <= cyc + 1;

   function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] c);
      logic [79:0] r;
      r          = {k[18:0], k[79:19]};
      r[79:76]   = SB[r[79:76]];
      r[19:15]   = r[19:15] ^ c;
      return r;
   endfunction

   // Key-schedule stage: loads K2 on key_start, steps to K(rc+2) on key_act.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN)                  ks_q <= '0;
      else if (bus.key_start_o) ks_q <= key_upd(bus.key_i, 5'd1);
      else if (bus.key_act_o)   ks_q <= key_upd(ks_q, bus.rc_o + 5'd1);
   end
   assign bus.krnd_i = ks_q;

   function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [79:0] k);
      logic [79:0] kr;
      logic [63:0] rk [33];
      logic [63:0] s;
      logic [63:0] t;
      kr = k;
      for (int r = 1; r <= 32; r++) begin
         rk[r] = kr[79:16];
         if (r < 32) kr = key_upd(kr, 5'(r));
      end
      s = p;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ rk[r];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
         t = '0;
         for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
         s = t;
      end
      return s ^ rk[32];
   endfunction

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_block(input logic [63:0] p, input logic [79:0] k, output int t0);
      @(negedge CK);
      bus.pt_i    = p;
      bus.key_i   = k;
      bus.start_i = 1'b1;
      #1 check("key_start_hi", 80'(bus.key_start_o), 80'd1);
      @(posedge CK);
      #1;
      bus.start_i = 1'b0;
      t0 = cyc;
      check("rc_first", 80'(bus.rc_o), 80'd1);
      check("busy_hi", 80'(bus.busy_o), 80'd1);
   endtask

   task automatic wait_done(input int t0, output int lat);
      int n;
      n = 0;
      while (bus.done_o !== 1'b1 && n < 40) begin
         @(posedge CK);
         #1;
         n++;
         if (bus.rc_o === 5'd31) check("key_act_final", 80'(bus.key_act_o), 80'd0);
      end
      lat = cyc - t0;
   endtask

   task automatic wait_rc(input logic [4:0] target);
      int n;
      n = 0;
      do begin
         @(negedge CK);
         n++;
      end while (bus.rc_o !== target && n < 40);
      check("wait_rc", 80'(bus.rc_o), 80'(target));
   endtask

   task automatic run_block(input logic [63:0] p, input logic [79:0] k,
                            input logic [63:0] exp, input string tag);
      int t0;
      int lat;
      start_block(p, k, t0);
      wait_done(t0, lat);
      check({tag, "_latency"}, 80'(lat), 80'd31);
      check({tag, "_done"}, 80'(bus.done_o), 80'd1);
      check({tag, "_ct"}, 80'(bus.ct_o), 80'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rp;
      logic [79:0] rk;
      logic [63:0] last_ct;
      int          t0;
      int          lat;

      bus.start_i = 1'b0;
      bus.pt_i    = '0;
      bus.key_i   = '0;
`ifdef PRESENT_ABORT_EN
      bus.abort_i = 1'b0;
`endif
      #2;
      check("rst_ct", 80'(bus.ct_o), 80'd0);
      check("rst_rc", 80'(bus.rc_o), 80'd0);
      check("rst_done", 80'(bus.done_o), 80'd0);
      check("rst_busy", 80'(bus.busy_o), 80'd0);
      check("rst_key_act", 80'(bus.key_act_o), 80'd0);
      @(negedge CK);
      RN = 1'b1;

      // Known-answer vectors, the last pair started back-to-back.
      run_block(64'h0, 80'h0, 64'h5579C1387B228445, "kat0");
      @(posedge CK);
      #1;
      check("done_one_cycle", 80'(bus.done_o), 80'd0);
      check("ct_hold", 80'(bus.ct_o), 80'h5579C1387B228445);
      check("idle_busy", 80'(bus.busy_o), 80'd0);
      check("idle_rc", 80'(bus.rc_o), 80'd0);
      run_block(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, "kat1");
      run_block({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, "kat2");
      run_block({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, "kat3");

      // Start while busy is ignored.
      start_block(64'h0, 80'h0, t0);
      wait_rc(5'd10);
      rp = {$urandom, $urandom};
      rk = 80'({$urandom, $urandom, $urandom});
      bus.pt_i    = rp;
      bus.key_i   = rk;
      bus.start_i = 1'b1;
      #1 check("key_start_busy", 80'(bus.key_start_o), 80'd0);
      @(posedge CK);
      #1;
      bus.start_i = 1'b0;
      check("rc_no_restart", 80'(bus.rc_o), 80'd11);
      wait_done(t0, lat);
      check("restart_latency", 80'(lat), 80'd31);
      check("restart_ct", 80'(bus.ct_o), 80'h5579C1387B228445);

      // Reset mid-block.
      rp = {$urandom, $urandom};
      rk = 80'({$urandom, $urandom, $urandom});
      start_block(rp, rk, t0);
      wait_rc(5'd15);
      #2 RN = 1'b0;
      #1;
      check("midrst_ct", 80'(bus.ct_o), 80'd0);
      check("midrst_rc", 80'(bus.rc_o), 80'd0);
      check("midrst_done", 80'(bus.done_o), 80'd0);
      check("midrst_busy", 80'(bus.busy_o), 80'd0);
      check("midrst_key_act", 80'(bus.key_act_o), 80'd0);
      repeat (3) @(posedge CK);
      #1 check("midrst_no_done", 80'(bus.done_o), 80'd0);
      @(negedge CK);
      RN = 1'b1;
      rp = {$urandom, $urandom};
      rk = 80'({$urandom, $urandom, $urandom});
      run_block(rp, rk, ref_encrypt(rp, rk), "after_rst");

      // Random blocks against the reference model.
      for (int i = 0; i < 6; i++) begin
         rp = {$urandom, $urandom};
         rk = 80'({$urandom, $urandom, $urandom});
         run_block(rp, rk, ref_encrypt(rp, rk), "rand");
      end
      last_ct = ref_encrypt(rp, rk);

`ifdef PRESENT_ABORT_EN
      rp = {$urandom, $urandom};
      rk = 80'({$urandom, $urandom, $urandom});
      start_block(rp, rk, t0);
      wait_rc(5'd20);
      bus.abort_i = 1'b1;
      @(posedge CK);
      #1;
      bus.abort_i = 1'b0;
      check("abort_busy", 80'(bus.busy_o), 80'd0);
      check("abort_rc", 80'(bus.rc_o), 80'd0);
      check("abort_done", 80'(bus.done_o), 80'd0);
      check("abort_ct", 80'(bus.ct_o), 80'(last_ct));
      repeat (15) @(posedge CK);
      #1 check("abort_no_done", 80'(bus.done_o), 80'd0);
      rp = {$urandom, $urandom};
      rk = 80'({$urandom, $urandom, $urandom});
      run_block(rp, rk, ref_encrypt(rp, rk), "after_abort");
`else
      check("final_ct", 80'(bus.ct_o), 80'(last_ct));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
